lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width (valid range 3..32).
REQ-002 SHALL have parameter TAPS, default 16'hB400, feedback tap mask, WIDTH bits.
REQ-003 SHALL have parameter MODE, default 0, 0 = Fibonacci, 1 = Galois.
REQ-004 SHALL have parameter SEED_DEFAULT, default 16'hACE1, reset and fallback seed (nonzero).
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1, advance one step per clk while high.
REQ-008 SHALL have port load, input, 1, load seed this cycle.
REQ-009 SHALL have port seed, input, WIDTH, value to load.
REQ-010 SHALL have port state, output, WIDTH, current register value.
REQ-011 SHALL have port seed_err, output, 1, one-cycle pulse when a zero seed is rejected.
REQ-012 SHALL have port period, output, WIDTH, last measured sequence period.
REQ-013 SHALL have port period_vld, output, 1, one-cycle pulse when period updates.

Function
REQ-014 Fibonacci step SHALL be: fb = XOR of state[i] for all i with TAPS[i]=1; next = {state[WIDTH-2:0], fb}.
REQ-015 Galois step SHALL be: next = state >> 1, then XOR with TAPS if the old state[0] was 1.
REQ-016 Priority per cycle SHALL be reset > load > en > hold.
REQ-017 On load with seed != 0, state SHALL equal seed on the next edge, with no step in the same cycle even if en is high.
REQ-018 On load with seed == 0, state SHALL take SEED_DEFAULT and seed_err SHALL pulse high for exactly one cycle.
REQ-019 With en low and load low, state SHALL hold.
REQ-020 state SHALL never be all-zero, because the only entry paths are reset, a nonzero load and a step from nonzero.
REQ-021 The block SHALL latch a reference register ref, which takes SEED_DEFAULT on reset and the accepted seed on load.

Reset
REQ-022 Asserting reset SHALL immediately force state = SEED_DEFAULT, ref = SEED_DEFAULT, seed_err = 0, period = 0, period_vld = 0 and the step counter = 0, independent of clk.
REQ-023 Reset asserted mid-sequence SHALL discard all progress, and the first step after release SHALL start from SEED_DEFAULT.
REQ-024 Deassertion SHALL take effect at the next rising clk, with no step on the release edge unless en is high.

Configuration
REQ-025 The period-measurement logic SHALL be included only when LFSR_PERIOD_CNT_EN is defined.
REQ-026 With LFSR_PERIOD_CNT_EN defined, the WIDTH-bit step counter SHALL behave as follows:
- clears on reset or load;
- increments on each en step, wrapping mod 2^WIDTH;
- when a step produces next == ref: period <= counter+1, period_vld pulses one cycle, counter clears.
REQ-027 Without LFSR_PERIOD_CNT_EN, period and period_vld SHALL remain as ports tied to 0, and no counter or ref register SHALL be synthesised.

Verification
REQ-028 Defaults, MODE=0, reset then en=1 SHALL produce this sequence: state after reset = 16'hACE1; first step = 16'h59C3; second step = 16'hB387.
REQ-029 Defaults, MODE=1, reset then en=1 SHALL produce this sequence: state after reset = 16'hACE1; first step = 16'hE270.
REQ-030 Load with seed=16'h0000 SHALL give state = 16'hACE1 next cycle and seed_err high for exactly 1 cycle.
REQ-031 Load and en high together with seed=16'h0001 SHALL give state = 16'h0001 (no step), with the sequence continuing from 16'h0001 afterward.
REQ-032 With LFSR_PERIOD_CNT_EN, both MODEs, en held high for 65535 steps from seed 16'hACE1 SHALL pulse period_vld once with period = 16'hFFFF and state back at 16'hACE1.
REQ-033 Reset pulsed at step 1000 of a run SHALL return state = 16'hACE1 asynchronously and clear period to 0, and the next 65535 steps SHALL reproduce REQ-032.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: configurable Fibonacci / Galois LFSR with zero-seed protection.
// A load of an all-zero seed is replaced by SEED_DEFAULT and flagged on
// seed_err, so the register can never lock up in the all-zero state.
// Optional period measurement is compiled in when LFSR_PERIOD_CNT_EN is
// defined; without it, period and period_vld are tied to zero.
module lfsr_gen #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
   parameter int               MODE         = 0,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(16'hACE1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state,
   output logic             seed_err,
   output logic [WIDTH-1:0] period,
   output logic             period_vld
);

   logic [WIDTH-1:0] state_reg;
   logic [WIDTH-1:0] state_next;
   logic             seed_err_reg;
   logic             seed_err_next;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_val;
   logic             seed_zero;

   // A zero seed is never accepted; the default seed stands in for it.
   assign seed_zero = (seed == '0);
   assign load_val  = seed_zero ? SEED_DEFAULT : seed;

   generate
      if (MODE == 0) begin : g_fib
         logic [WIDTH-1:0] tap_bits;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = state_reg[gi] & TAPS[gi];
         end
         // Fibonacci: shift left, feedback is the parity of the tapped bits.
         assign step_val = {state_reg[WIDTH-2:0], ^tap_bits};
      end else begin : g_gal
         // Galois: shift right, fold the taps in when the bit shifted out is 1.
         for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign step_val[gi] = state_reg[gi+1] ^ (TAPS[gi] & state_reg[0]);
         end
         assign step_val[WIDTH-1] = TAPS[WIDTH-1] & state_reg[0];
      end
   endgenerate

   // Next-state selection: load has priority over a step; otherwise hold.
   always_comb begin
      state_next    = state_reg;
      seed_err_next = 1'b0;
      if (load) begin
         state_next    = load_val;
         seed_err_next = seed_zero;
      end else if (en) begin
         state_next = step_val;
      end
   end

   // LFSR register and the seed-error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= SEED_DEFAULT;
         seed_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         seed_err_reg <= seed_err_next;
      end
   end

   assign state    = state_reg;
   assign seed_err = seed_err_reg;

`ifdef LFSR_PERIOD_CNT_EN
   logic [WIDTH-1:0] ref_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] period_reg;
   logic             period_vld_reg;

   // Period measurement: count steps until the sequence returns to the
   // reference (last accepted seed); report count+1 and restart counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_reg        <= SEED_DEFAULT;
         cnt_reg        <= '0;
         period_reg     <= '0;
         period_vld_reg <= 1'b0;
      end else begin
         period_vld_reg <= 1'b0;
         if (load) begin
            ref_reg <= load_val;
            cnt_reg <= '0;
         end else if (en) begin
            if (step_val == ref_reg) begin
               period_reg     <= cnt_reg + 1'b1;
               period_vld_reg <= 1'b1;
               cnt_reg        <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign period     = period_reg;
   assign period_vld = period_vld_reg;
`else
   assign period     = '0;
   assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: table-driven vectors for both LFSR modes, hand-written
// asynchronous-reset sequences, and a long model-checked run covering the
// full 16-bit period (when LFSR_PERIOD_CNT_EN is defined).
module tb_lfsr_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        load;
   logic [15:0] seed;
   logic [3:0]  seed4;

   logic [15:0] state0, state1, period0, period1;
   logic        seed_err0, seed_err1, vld0, vld1;
   logic [3:0]  state2, period2;
   logic        seed_err2, vld2;

   assign seed4 = seed[3:0];

   always #5 clk = ~clk;

   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(0), .SEED_DEFAULT(16'hACE1)) dut0 (
      .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
      .state(state0), .seed_err(seed_err0), .period(period0), .period_vld(vld0));

   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(1), .SEED_DEFAULT(16'hACE1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
      .state(state1), .seed_err(seed_err1), .period(period1), .period_vld(vld1));

   // Small Galois instance (period 15) to exercise repeated period reports.
   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .MODE(1), .SEED_DEFAULT(4'h1)) dut2 (
      .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed4),
      .state(state2), .seed_err(seed_err2), .period(period2), .period_vld(vld2));

   typedef struct {
      logic        en;
      logic        load;
      logic [15:0] seed;
      logic [15:0] exp0;
      logic [15:0] exp1;
      logic        err;
   } vec_t;

   typedef struct {
      logic [15:0] s0;
      logic [15:0] s1;
      logic        err;
   } exp_t;

   localparam int NV = 12;
`ifdef LFSR_PERIOD_CNT_EN
   localparam int RUN_STEPS = 65535;
`else
   localparam int RUN_STEPS = 2000;
`endif

   vec_t vecs[NV];
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   int mism;
   int pulses0, pulses1, pulses2, bad2;
   int pstep0, pstep1;
   logic [15:0] pper0, pper1, pst0, pst1;
   logic [15:0] model0, model1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   function automatic logic [15:0] fib16(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   function automatic logic [15:0] gal16(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Run n enabled steps, comparing both 16-bit instances against the
   // reference model and recording period reports.
   task automatic run(input int n);
      exp_t e;
      mism    = 0;
      pulses0 = 0; pulses1 = 0; pulses2 = 0; bad2 = 0;
      pstep0  = 0; pstep1  = 0;
      for (int k = 1; k <= n; k++) begin
         model0 = fib16(model0);
         model1 = gal16(model1);
         sb.push_back('{model0, model1, 1'b0});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         if (state0 !== e.s0 || state1 !== e.s1) mism++;
         if (vld0) begin pulses0++; pstep0 = k; pper0 = period0; pst0 = state0; end
         if (vld1) begin pulses1++; pstep1 = k; pper1 = period1; pst1 = state1; end
         if (vld2) begin
            pulses2++;
            if (period2 !== 4'd15) bad2++;
         end
      end
   endtask

   initial begin
      exp_t e;

      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h59C3, 16'hE270, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'h0000, 16'hB387, 16'h7138, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'hB387, 16'h7138, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 16'h0000, 16'hACE1, 16'hACE1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'hACE1, 16'hACE1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 16'hB400, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h5A00, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'h1234, 16'h1234, 16'h1234, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h2469, 16'h091A, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 16'h0000, 16'hACE1, 16'hACE1, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h59C3, 16'hE270, 1'b0};

      // Reset asserted before any clock edge: outputs must already be forced.
      reset = 1'b1; en = 1'b0; load = 1'b0; seed = 16'h0000;
      #2;
      check("reset state0", 32'(state0), 32'hACE1);
      check("reset state1", 32'(state1), 32'hACE1);
      check("reset seed_err0", 32'(seed_err0), 32'h0);
      check("reset period0", 32'(period0), 32'h0);
      check("reset period_vld0", 32'(vld0), 32'h0);

      // Release with en low: no step on the release edge.
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("release hold state0", 32'(state0), 32'hACE1);
      check("release hold state1", 32'(state1), 32'hACE1);

      // Table-driven vectors through the scoreboard.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         en   = vecs[i].en;
         load = vecs[i].load;
         seed = vecs[i].seed;
         sb.push_back('{vecs[i].exp0, vecs[i].exp1, vecs[i].err});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("vec%0d state0", i), 32'(state0), 32'(e.s0));
         check($sformatf("vec%0d state1", i), 32'(state1), 32'(e.s1));
         check($sformatf("vec%0d seed_err0", i), 32'(seed_err0), 32'(e.err));
         check($sformatf("vec%0d seed_err1", i), 32'(seed_err1), 32'(e.err));
         check($sformatf("vec%0d period_vld0", i), 32'(vld0), 32'h0);
      end

      // Mid-cycle asynchronous reset while running: takes effect without a clock.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async reset state0", 32'(state0), 32'hACE1);
      check("async reset state1", 32'(state1), 32'hACE1);
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      load  = 1'b0;
      @(posedge clk);
      #1;
      check("post-reset step state0", 32'(state0), 32'h59C3);
      check("post-reset step state1", 32'(state1), 32'hE270);

      // Clean start, 1000 steps, then reset in the middle of the run.
      @(negedge clk);
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      reset = 1'b0; en = 1'b1;
      model0 = 16'hACE1; model1 = 16'hACE1;
      run(1000);
      check("run1000 model mismatches", 32'(mism), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
      check("small period before reset", 32'(period2), 32'd15);
`endif
      #2;
      reset = 1'b1;
      #1;
      check("step1000 reset state0", 32'(state0), 32'hACE1);
      check("step1000 reset state1", 32'(state1), 32'hACE1);
      check("step1000 reset period0", 32'(period0), 32'h0);
      check("step1000 reset period2", 32'(period2), 32'h0);
      check("step1000 reset state2", 32'(state2), 32'h1);
      @(negedge clk);
      reset = 1'b0;

      // Full run after reset: model-checked every step.
      model0 = 16'hACE1; model1 = 16'hACE1;
      run(RUN_STEPS);
      check("long run model mismatches", 32'(mism), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
      check("fib period pulses", 32'(pulses0), 32'd1);
      check("fib pulse step", 32'(pstep0), 32'd65535);
      check("fib period value", 32'(pper0), 32'hFFFF);
      check("fib state at pulse", 32'(pst0), 32'hACE1);
      check("gal period pulses", 32'(pulses1), 32'd1);
      check("gal pulse step", 32'(pstep1), 32'd65535);
      check("gal period value", 32'(pper1), 32'hFFFF);
      check("gal state at pulse", 32'(pst1), 32'hACE1);
      check("small period pulses", 32'(pulses2), 32'd4369);
      check("small bad periods", 32'(bad2), 32'h0);
`else
      check("fib period pulses", 32'(pulses0), 32'd0);
      check("gal period pulses", 32'(pulses1), 32'd0);
      check("fib period tied", 32'(period0), 32'h0);
      check("small period pulses", 32'(pulses2), 32'd0);
`endif

      en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
